mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Iterative unsigned shift-and-add multiplier controller for the ALU.
//  Drives one internal adder instance (OPERAND_LENGTH+1 bits wide, add mode,
//  alu_op_select=3'b000) once per cycle and returns a 2N-bit product.
//  Sits beside the ALU; the EX stage issues start and stalls on busy.
// PARAMETERS
//  OPERAND_LENGTH  32  operand width N; the product is 2N bits
// PORTS
//  clk           in   1    clock, rising edge
//  rst_n         in   1    asynchronous reset, active-low
//  start         in   1    request; sampled only in IDLE or DONE
//  flush         in   1    synchronous abort to IDLE; no result
//  opd1          in   N    multiplicand, captured on accepted start
//  opd2          in   N    multiplier, captured on accepted start
//  busy          out  1    high while in BUSY
//  result_valid  out  1    one-cycle pulse: product is ready
//  result_lo     out  N    product[N-1:0]
//  result_hi     out  N    product[2N-1:N]
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, busy=0, result_valid=0,
//   result_lo=0, result_hi=0, iteration counter=0; all registers cleared.
//  FSM states:
//   IDLE: on start, mcand<=opd1, lo<=opd2, hi<=0, cnt<=0, go to BUSY.
//   BUSY: iterate. After N iterations (cnt==N-1 this cycle), go to DONE.
//   DONE: result_valid=1 for exactly this cycle. Next state is IDLE;
//    a start in DONE is accepted as it would be in IDLE (back-to-back).
//  Iteration (each BUSY cycle):
//   sum[N:0] = {1'b0,hi} + (lo[0] ? {1'b0,mcand} : 0), computed by the adder.
//   {hi,lo} <= {sum[N:0], lo[N-1:1]}, a right shift that keeps the carry.
//   cnt <= cnt+1.
//  Outputs: result_lo/result_hi are registered copies of lo/hi.
//   They update only on the BUSY->DONE transition.
//   They hold until the next DONE, so they remain stable through IDLE and BUSY.
//  Latency: start accepted at edge k; busy=1 for cycles k+1..k+N;
//   result_valid=1 in cycle k+N+1. Throughput: one product per N+1 cycles.
//  busy is 0 in IDLE and in DONE.
//  Handshake rules:
//   - start in BUSY is ignored; it is neither queued nor an error.
//   - Operands are captured at acceptance. Later changes to opd1/opd2 have
//     no effect on the operation in flight.
//  flush: priority over start in every state.
//   - In BUSY: go to IDLE next cycle, no result_valid, results not updated.
//   - In DONE: result_valid still pulses this cycle; no new start is taken.
//  Reset mid-operation: immediate return to IDLE; the partial product is
//   discarded and the result registers are cleared.
//  Arithmetic: unsigned only. The product is exact (2N bits, no overflow).
//   The carry bit sum[N] is never dropped.
//  Boundary values:
//   - opd2=0 or opd1=0: product 0 after the full N cycles (without the option).
//   - All-ones operands: product = (2^N-1)^2, which exercises the carry on
//     every iteration.
// CONFIGURATION
//  MUL_ZERO_SKIP_EN
//   Defined: on an accepted start with opd1==0 or opd2==0, the FSM goes
//    directly to DONE with result=0. result_valid fires at k+1 and busy
//    never asserts.
//   Undefined: every operation takes N BUSY cycles, regardless of operands.
//  All other behaviour is identical in both builds.
// TESTING (N=8 unless stated)
//  1. start, opd1=8'd13, opd2=8'd11 -> busy cycles 1..8, result_valid at
//     cycle 9, hi=8'h00, lo=8'h8F.
//  2. opd1=opd2=8'hFF -> hi=8'hFE, lo=8'h01. The carry is preserved on
//     every step.
//  3. opd1=8'd5, opd2=0 -> product 0. result_valid at cycle 9 (macro off)
//     or cycle 1 with busy=0 (macro on).
//  4. start pulsed at BUSY cycle 3 with new operands -> ignored; result is
//     unchanged from the first op.
//     start asserted in DONE -> second op accepted, busy in the next cycle.
//  5. flush in BUSY cycle 4 -> IDLE next cycle, no result_valid, previous
//     result_lo/hi held.
//     flush and start together in IDLE -> start ignored.
//  6. rst_n low at BUSY cycle 5 -> all outputs 0 immediately (async).
//     After release, a fresh op computes correctly.
//     Random regression, N=32, 1000 ops, checked against the reference model
//     opd1*opd2.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative unsigned shift-and-add multiplier, N BUSY cycles per 2N-bit product.
// Optional MUL_ZERO_SKIP_EN: a zero operand completes straight to DONE with a zero result.
module mul_sequencer #(
  parameter int OPERAND_LENGTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      flush,
  input  logic [OPERAND_LENGTH-1:0] opd1,
  input  logic [OPERAND_LENGTH-1:0] opd2,
  output logic                      busy,
  output logic                      result_valid,
  output logic [OPERAND_LENGTH-1:0] result_lo,
  output logic [OPERAND_LENGTH-1:0] result_hi
);
  localparam int N  = OPERAND_LENGTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] mcand_q, mcand_d, lo_q, lo_d, hi_q, hi_d;
  logic [N-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0] sum;
  logic accept, last, zero_op;
  // adder in add mode; the carry sum[N] shifts into hi so nothing is lost
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign accept = (state_q != BUSY) && start && !flush;
  assign last = cnt_q == CW'(N - 1);
`ifdef MUL_ZERO_SKIP_EN
  assign zero_op = (opd1 == '0) || (opd2 == '0);
`else
  assign zero_op = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    if (accept) begin
      mcand_d = opd1;
      lo_d    = opd2;
      hi_d    = '0;
      cnt_d   = '0;
      state_d = zero_op ? DONE : BUSY;
      if (zero_op) begin
        res_lo_d = '0;
        res_hi_d = '0;
      end
    end else if (state_q == BUSY) begin
      if (flush) state_d = IDLE;
      else begin
        hi_d  = sum[N:1];
        lo_d  = {sum[0], lo_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d  = DONE;
          res_hi_d = hi_d;
          res_lo_d = lo_d;
        end
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end
  assign busy         = state_q == BUSY;
  assign result_valid = state_q == DONE;
  assign result_lo    = res_lo_q;
  assign result_hi    = res_hi_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed vector table and corner sequences on N=8, random products on N=32.
module tb_mul_sequencer;
`ifdef MUL_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic s8, f8, s32, f32;
  logic [7:0] a8, b8;
  logic [31:0] a32, b32;
  logic busy8, rv8, busy32, rv32;
  logic [7:0] lo8, hi8;
  logic [31:0] lo32, hi32;
  mul_sequencer #(.OPERAND_LENGTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .flush(f8), .opd1(a8), .opd2(b8),
    .busy(busy8), .result_valid(rv8), .result_lo(lo8), .result_hi(hi8));
  mul_sequencer #(.OPERAND_LENGTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(s32), .flush(f32), .opd1(a32), .opd2(b32),
    .busy(busy32), .result_valid(rv32), .result_lo(lo32), .result_hi(hi32));
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t v[12];
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output int nb);
    a8 = a; b8 = b; s8 = 1'b1;
    tick;
    s8 = 1'b0; lat = 1; nb = 0;
    while (!rv8 && lat < 40) begin
      if (busy8) nb++;
      tick;
      lat++;
    end
  endtask
  initial begin
    int lat, nb, seen;
    logic [63:0] exp64;
    v[0]  = '{8'd13,  8'd11,  16'h008F};
    v[1]  = '{8'hFF,  8'hFF,  16'hFE01};
    v[2]  = '{8'd5,   8'd0,   16'h0000};
    v[3]  = '{8'd0,   8'd7,   16'h0000};
    v[4]  = '{8'd1,   8'd1,   16'h0001};
    v[5]  = '{8'h80,  8'h02,  16'h0100};
    v[6]  = '{8'h10,  8'h10,  16'h0100};
    v[7]  = '{8'd200, 8'd3,   16'h0258};
    v[8]  = '{8'h80,  8'h80,  16'h4000};
    v[9]  = '{8'hFF,  8'h02,  16'h01FE};
    v[10] = '{8'h01,  8'hFF,  16'h00FF};
    v[11] = '{8'd12,  8'd12,  16'h0090};
    s8 = 0; f8 = 0; a8 = 0; b8 = 0; s32 = 0; f32 = 0; a32 = 0; b32 = 0;
    #12;
    chk("reset_outputs", {busy8, rv8, hi8, lo8}, 64'd0);
    chk("reset_outputs32", {busy32, rv32, hi32, lo32}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    for (int i = 0; i < 12; i++) begin
      logic zero;
      zero = (v[i].a == 0) || (v[i].b == 0);
      run8(v[i].a, v[i].b, lat, nb);
      chk($sformatf("vec%0d_latency", i), lat, (ZS && zero) ? 1 : 9);
      chk($sformatf("vec%0d_busy_cycles", i), nb, (ZS && zero) ? 0 : 8);
      chk($sformatf("vec%0d_product", i), {hi8, lo8}, v[i].p);
      chk($sformatf("vec%0d_busy_in_done", i), busy8, 0);
    end
    tick;
    a8 = 8'd13; b8 = 8'd11; s8 = 1'b1;
    tick;
    s8 = 1'b0;
    tick; tick;
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
    tick;
    s8 = 1'b0; lat = 4;
    while (!rv8 && lat < 40) begin tick; lat++; end
    chk("ignored_start_latency", lat, 9);
    chk("ignored_start_product", {hi8, lo8}, 16'h008F);
    a8 = 8'd3; b8 = 8'd4; s8 = 1'b1;
    tick;
    s8 = 1'b0;
    chk("b2b_busy_next", busy8, 1);
    lat = 1;
    while (!rv8 && lat < 40) begin tick; lat++; end
    chk("b2b_latency", lat, 9);
    chk("b2b_product", {hi8, lo8}, 16'd12);
    a8 = 8'd200; b8 = 8'd3; s8 = 1'b1;
    tick;
    s8 = 1'b0;
    tick; tick; tick;
    f8 = 1'b1;
    tick;
    f8 = 1'b0;
    chk("flush_busy_low", busy8, 0);
    chk("flush_no_valid", rv8, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rv8 || busy8) seen++;
      tick;
    end
    chk("flush_stays_idle", seen, 0);
    chk("flush_result_held", {hi8, lo8}, 16'd12);
    a8 = 8'd7; b8 = 8'd9; s8 = 1'b1; f8 = 1'b1;
    tick;
    s8 = 1'b0; f8 = 1'b0;
    chk("flush_start_idle_busy", busy8, 0);
    chk("flush_start_idle_valid", rv8, 0);
    run8(8'd2, 8'd3, lat, nb);
    chk("done_flush_valid", rv8, 1);
    a8 = 8'd9; b8 = 8'd9; s8 = 1'b1; f8 = 1'b1;
    tick;
    s8 = 1'b0; f8 = 1'b0;
    chk("done_flush_state", {busy8, rv8}, 0);
    chk("done_flush_product", {hi8, lo8}, 16'd6);
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
    tick;
    s8 = 1'b0;
    tick; tick; tick; tick;
    chk("pre_reset_busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy8, rv8, hi8, lo8}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    run8(8'h21, 8'h07, lat, nb);
    chk("post_reset_latency", lat, 9);
    chk("post_reset_product", {hi8, lo8}, 16'h00E7);
    for (int i = 0; i < 1000; i++) begin
      a32 = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      b32 = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      exp64 = 64'(a32) * 64'(b32);
      s32 = 1'b1;
      tick;
      s32 = 1'b0; lat = 1;
      while (!rv32 && lat < 80) begin tick; lat++; end
      chk($sformatf("rand%0d_latency", i), lat, (ZS && (a32 == 0 || b32 == 0)) ? 1 : 33);
      chk($sformatf("rand%0d_product", i), {hi32, lo32}, exp64);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
